// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply host driver.
// Holds the FSM state enum, the matrix-select encodings and the result width.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    GO,
    COLLECT,
    FINISH
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Each result element is this many link bytes wide (2*DW bits).
  localparam int RES_BYTES = 2;

  function automatic int res_width(input int dw);
    return RES_BYTES * dw;
  endfunction

endpackage

// File: rtl/mm_result_assembler.sv
// Packs a stream of result bytes, low byte first, into consecutive words.
// 'last' flags the byte that completes the final word; 'full' holds afterwards.
module mm_result_assembler
  import mm_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int DW     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [DW-1:0]                  res_byte,
  input  logic                           valid,
  output logic [NWORDS*RES_BYTES*DW-1:0] words,
  output logic                           full,
  output logic                           last
);

  localparam int NBYTES = NWORDS * RES_BYTES;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NBYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  logic [CW-1:0] cnt_reg;
  logic          accept;

  assign full   = (cnt_reg == FULL_CNT);
  assign accept = valid && !full;
  assign last   = accept && (cnt_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Byte k of the stream lands in lane k, which is exactly row-major,
  // low-byte-first placement of the packed words.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [DW-1:0] lane_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_reg <= '0;
      end else if (accept && (cnt_reg == CW'(gi))) begin
        lane_reg <= res_byte;
      end
    end

    assign words[gi*DW +: DW] = lane_reg;
  end

endmodule

// File: rtl/mm_host_driver.sv
// Host-side driver: streams matrices A and B to a multiplier, strobes compute,
// then collects the 2*DW-bit result elements. Optional collect timeout: MM_DRV_TIMEOUT_EN.
module mm_host_driver
  import mm_pkg::*;
#(
  parameter int N       = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N*N*DW-1:0]             a_flat,
  input  logic [N*N*DW-1:0]             b_flat,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [N*N*RES_BYTES*DW-1:0]   c_flat,
  output logic [DW-1:0]                 mm_data,
  output logic                          mm_valid,
  output logic                          mm_sel,
  output logic                          mm_go,
  input  logic [DW-1:0]                 mm_res,
  input  logic                          mm_res_valid
);

  localparam int NN = N * N;
  localparam int EW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(NN - 1);

  state_t                         state_reg, state_next;
  logic [EW-1:0]                  elem_reg, elem_next;
  logic [NN*RES_BYTES*DW-1:0]     c_reg;
  logic [NN*RES_BYTES*DW-1:0]     words;
  logic                           asm_valid, asm_clear, asm_full, asm_last;
  logic                           idle_expired;
  logic                           timed_out;

  assign asm_valid = mm_res_valid && (state_reg == COLLECT);
  assign asm_clear = (state_reg != COLLECT);

  mm_result_assembler #(
    .NWORDS (NN),
    .DW     (DW)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (asm_clear),
    .res_byte (mm_res),
    .valid    (asm_valid),
    .words    (words),
    .full     (asm_full),
    .last     (asm_last)
  );

`ifdef MM_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_cnt_reg;
  logic          timed_out_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_reg <= '0;
    end else if ((state_reg != COLLECT) || mm_res_valid) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th consecutive empty COLLECT cycle.
  assign idle_expired = (state_reg == COLLECT) && !mm_res_valid &&
                        (idle_cnt_reg == IDLE_LIMIT);

  // Set on the edge into FINISH, so it marks exactly that FINISH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      timed_out_reg <= 1'b0;
    end else begin
      timed_out_reg <= idle_expired;
    end
  end

  assign timed_out = timed_out_reg;
  assign err       = (state_reg == FINISH) && timed_out_reg;
`else
  assign idle_expired = 1'b0;
  assign timed_out    = 1'b0;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      elem_reg  <= '0;
    end else begin
      state_reg <= state_next;
      elem_reg  <= elem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg <= '0;
    end else if ((state_reg == FINISH) && !timed_out) begin
      c_reg <= words;
    end
  end

  // The new result is already visible during the done cycle, then held.
  assign c_flat = ((state_reg == FINISH) && !timed_out) ? words : c_reg;

  always_comb begin
    state_next = state_reg;
    elem_next  = elem_reg;
    busy       = 1'b1;
    done       = 1'b0;
    mm_valid   = 1'b0;
    mm_sel     = SEL_A;
    mm_data    = '0;
    mm_go      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        busy      = 1'b0;
        elem_next = '0;
        if (start) begin
          state_next = LOAD_A;
        end
      end

      LOAD_A: begin
        mm_valid = 1'b1;
        mm_sel   = SEL_A;
        mm_data  = a_flat[int'(elem_reg)*DW +: DW];
        if (elem_reg == ELEM_LAST) begin
          elem_next  = '0;
          state_next = LOAD_B;
        end else begin
          elem_next = elem_reg + 1'b1;
        end
      end

      LOAD_B: begin
        mm_valid = 1'b1;
        mm_sel   = SEL_B;
        mm_data  = b_flat[int'(elem_reg)*DW +: DW];
        if (elem_reg == ELEM_LAST) begin
          elem_next  = '0;
          state_next = GO;
        end else begin
          elem_next = elem_reg + 1'b1;
        end
      end

      GO: begin
        mm_go      = 1'b1;
        state_next = COLLECT;
      end

      COLLECT: begin
        if (asm_last || asm_full || idle_expired) begin
          state_next = FINISH;
        end
      end

      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mm_host_driver.sv
// Self-checking bench for mm_host_driver (N=2, DW=8): a cycle-level model
// derived from the transaction timing rules, plus hand-computed literal checks.
module tb_mm_host_driver;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int NN = N * N;
  localparam int NB = NN * 2;
`ifdef MM_DRV_TIMEOUT_EN
  localparam int TMO    = 16;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NN*DW-1:0] a_flat, b_flat;
  logic            busy, done, err;
  logic [63:0]     c_flat;
  logic [DW-1:0]   mm_data;
  logic            mm_valid, mm_sel, mm_go;
  logic [DW-1:0]   mm_res;
  logic            mm_res_valid;

  mm_host_driver #(
    .N       (N),
    .DW      (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_flat       (a_flat),
    .b_flat       (b_flat),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .c_flat       (c_flat),
    .mm_data      (mm_data),
    .mm_valid     (mm_valid),
    .mm_sel       (mm_sel),
    .mm_go        (mm_go),
    .mm_res       (mm_res),
    .mm_res_valid (mm_res_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0;
  int done_cyc = -1, err_cyc = -1, go_cyc = -1;

  // Model state: m_cyc = 0 idle, 1..NN load A, NN+1..2NN load B, 2NN+1 go, above that collect.
  int          m_cyc = 0, m_got = 0, m_idle = 0;
  bit          m_fin = 0, m_err = 0;
  logic [15:0] m_elem [NN];
  logic [63:0] c_exp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] product(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b);
    logic [63:0] r;
    int          s;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) begin
          s += int'(a[(i*N+k)*DW +: DW]) * int'(b[(k*N+j)*DW +: DW]);
        end
        r[(i*N+j)*16 +: 16] = 16'(s);
      end
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: check every cycle at the falling edge, then advance the model.
  initial begin
    logic          e_busy, e_done, e_err, e_valid, e_sel, e_go;
    logic [DW-1:0] e_data;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_busy  = (m_cyc != 0) || m_fin;
      e_done  = m_fin;
      e_err   = m_fin && m_err;
      e_valid = !m_fin && (m_cyc >= 1) && (m_cyc <= 2*NN);
      e_sel   = e_valid && (m_cyc > NN);
      e_go    = !m_fin && (m_cyc == 2*NN+1);
      e_data  = '0;
      if (e_valid) e_data = (m_cyc <= NN) ? a_flat[(m_cyc-1)*DW +: DW] : b_flat[(m_cyc-NN-1)*DW +: DW];
      chk("ctrl{busy,done,err,valid,go}", 64'({busy, done, err, mm_valid, mm_go}),
          64'({e_busy, e_done, e_err, e_valid, e_go}));
      chk("mm_data", 64'(mm_data), 64'(e_data));
      if (e_valid) chk("mm_sel", 64'(mm_sel), 64'(e_sel));
      chk("c_flat", c_flat, c_exp);
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (mm_go === 1'b1) go_cyc = cyc;

      if (rst) begin
        m_cyc = 0; m_fin = 0; m_err = 0; m_got = 0; m_idle = 0; c_exp = '0;
      end else if (m_fin) begin
        m_fin = 0; m_cyc = 0;
      end else if (m_cyc == 0) begin
        if (start) m_cyc = 1;
      end else if (m_cyc <= 2*NN) begin
        m_cyc++;
      end else if (m_cyc == 2*NN+1) begin
        m_cyc++; m_got = 0; m_idle = 0;
        for (int e = 0; e < NN; e++) m_elem[e] = '0;
      end else if (mm_res_valid) begin
        m_elem[m_got/2] = m_elem[m_got/2] | (16'(mm_res) << (DW*(m_got%2)));
        m_got++; m_idle = 0;
        if (m_got == NB) begin
          m_fin = 1; m_err = 0;
          for (int e = 0; e < NN; e++) c_exp[e*16 +: 16] = m_elem[e];
        end
      end else begin
        m_idle++;
        if (TMO_EN && m_idle == TMO) begin m_fin = 1; m_err = 1; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one transaction; bytes are fed from the first COLLECT cycle, low byte first,
  // with an optional one-cycle gap before byte index 'gap'. Returns the start cycle.
  task automatic run_txn(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b,
                         input logic [63:0] res, input int gap, input bit feed,
                         output int t0, output int last_cyc);
    a_flat = a;
    b_flat = b;
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < t0 + 2*NN + 2) tick();
    last_cyc = -1;
    if (feed) begin
      for (int i = 0; i < NB; i++) begin
        if (i == gap) begin
          mm_res_valid = 1'b0;
          tick();
        end
        mm_res = res[i*8 +: 8];
        mm_res_valid = 1'b1;
        last_cyc = cyc;
        tick();
      end
      mm_res_valid = 1'b0;
      mm_res = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0, last_cyc, d0;
    logic [63:0] p1, p2, saved;
    rst = 1'b1; start = 1'b0; a_flat = '0; b_flat = '0; mm_res = '0; mm_res_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_c_flat", c_flat, 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_mm_valid", 64'(mm_valid), 64'h0);
    tick();

    // Worked example: A=[1,2;3,4], B=[5,6;7,8], gap after the third byte.
    d0 = done_cnt;
    run_txn({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5},
            64'h0032_002B_0016_0013, 3, 1'b1, t0, last_cyc);
    repeat (2) tick();
    chk("ex1_go_cycle", 64'(go_cyc - t0), 64'd9);
    chk("ex1_done_count", 64'(done_cnt - d0), 64'd1);
    chk("ex1_done_cycle", 64'(done_cyc - last_cyc), 64'd1);
    chk("ex1_c_flat", c_flat, {16'd50, 16'd43, 16'd22, 16'd19});
    chk("ex1_model_pin", c_exp, 64'h0032_002B_0016_0013);
    chk("ex1_busy_after", 64'(busy), 64'h0);

    // Wide operands exercising high result bytes; no gap.
    p2 = product({8'd255, 8'd3, 8'd17, 8'd200}, {8'd100, 8'd9, 8'd2, 8'd250});
    run_txn({8'd255, 8'd3, 8'd17, 8'd200}, {8'd100, 8'd9, 8'd2, 8'd250}, p2, -1, 1'b1, t0, last_cyc);
    repeat (2) tick();
    chk("ex2_c00", 64'(c_flat[15:0]), 64'd50153);
    chk("ex2_c11", 64'(c_flat[63:48]), 64'd25506);
    chk("ex2_c_flat", c_flat, p2);

    // Stray result byte while idle must be ignored.
    d0 = done_cnt;
    saved = p2;
    mm_res = 8'hAA; mm_res_valid = 1'b1;
    tick();
    mm_res_valid = 1'b0; mm_res = '0;
    repeat (5) tick();
    chk("idle_byte_c_flat", c_flat, saved);
    chk("idle_byte_no_done", 64'(done_cnt - d0), 64'd0);

    // start held high: back-to-back transactions, each re-entering from IDLE.
    d0 = done_cnt;
    a_flat = {8'd9, 8'd8, 8'd7, 8'd6};
    b_flat = {8'd1, 8'd0, 8'd0, 8'd1};
    mm_res_valid = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      mm_res = 8'(cyc);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      mm_res = 8'(cyc);
      tick();
    end
    mm_res_valid = 1'b0; mm_res = '0;
    chk("held_start_two_txns", 64'(done_cnt - d0), 64'd2);

    // Reset in the middle of LOAD_B aborts silently.
    d0 = done_cnt;
    a_flat = {8'd1, 8'd1, 8'd1, 8'd1};
    b_flat = {8'd2, 8'd2, 8'd2, 8'd2};
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < t0 + 6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_mm_valid", 64'(mm_valid), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_c_flat", c_flat, 64'h0);
    repeat (20) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    if (TMO_EN) begin
      p1 = product({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
      run_txn({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, p1, -1, 1'b1, t0, last_cyc);
      repeat (2) tick();
      d0 = err_cnt;
      run_txn({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 64'h0, -1, 1'b0, t0, last_cyc);
      for (int i = 0; i < 40 && err_cnt == d0; i++) tick();
      tick();
      chk("tmo_err_count", 64'(err_cnt - d0), 64'd1);
      chk("tmo_err_cycle", 64'(err_cyc - t0), 64'd26);
      chk("tmo_done_with_err", 64'(done_cyc), 64'(err_cyc));
      chk("tmo_c_flat_kept", c_flat, {16'd50, 16'd43, 16'd22, 16'd19});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
